// File: rtl/param_common_bus_pkg.sv
// Shared select encodings and error-flag layout for the parametrised common bus.
package param_common_bus_pkg;

    localparam int unsigned SEL_NONE     = 0;
    localparam int unsigned SEL_REG_BASE = 1;
    localparam int unsigned SEL_MEM_OFS  = 1;
    localparam int unsigned SEL_EXT_OFS  = 2;

    localparam int unsigned ERR_W        = 3;
    localparam int unsigned ERR_CONFLICT = 0;
    localparam int unsigned ERR_RW       = 1;
    localparam int unsigned ERR_SEL      = 2;

    // Memory and external selects sit just above the register selects.
    function automatic int unsigned sel_mem(input int unsigned num_regs);
        return num_regs + SEL_MEM_OFS;
    endfunction

    function automatic int unsigned sel_ext(input int unsigned num_regs);
        return num_regs + SEL_EXT_OFS;
    endfunction

endpackage

// File: rtl/bus_reg.sv
// One bus register: clear beats load beats increment, otherwise hold.
module bus_reg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ld,
    input  logic              inr,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (inr) begin
            q <= q + DATA_W'(1);
        end
    end

endmodule

// File: rtl/param_common_bus.sv
// Parametrised common bus: NUM_REGS registers, a registered-read memory and an
// external port share one bus; illegal control combinations raise sticky flags.
module param_common_bus
    import param_common_bus_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 6,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned MEM_AW   = 8,
    parameter int unsigned ADDR_IDX = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REGS-1:0]        ld,
    input  logic [NUM_REGS-1:0]        inr,
    input  logic [NUM_REGS-1:0]        clr,
    input  logic [SEL_W-1:0]           select,
    input  logic                       read,
    input  logic                       write,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       err_clr,
    output logic [DATA_W-1:0]          data_out,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [ERR_W-1:0]           err
);

    localparam int unsigned SEL_MEM   = sel_mem(NUM_REGS);
    localparam int unsigned SEL_EXT   = sel_ext(NUM_REGS);
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

    if ((2 ** SEL_W) < (NUM_REGS + 3)) begin : g_sel_w_check
        $error("param_common_bus: SEL_W too narrow for NUM_REGS");
    end
    if (ADDR_IDX >= NUM_REGS) begin : g_addr_idx_check
        $error("param_common_bus: ADDR_IDX out of range");
    end

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] mem  [MEM_DEPTH];
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] bus;
    logic [NUM_REGS-1:0] conflict;
    logic [MEM_AW-1:0] mem_addr;
    logic              sel_bad;
    logic [ERR_W-1:0]  err_set;

    // Registers load the pre-edge bus, so same-cycle swaps need no special path.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        bus_reg #(.DATA_W(DATA_W)) u_reg (
            .clock   (clock),
            .reset_n (reset_n),
            .ld      (ld[k]),
            .inr     (inr[k]),
            .clr     (clr[k]),
            .d       (bus),
            .q       (regs[k])
        );
        assign reg_q[k*DATA_W +: DATA_W] = regs[k];
        assign conflict[k] = (ld[k] & inr[k]) | (ld[k] & clr[k]) | (inr[k] & clr[k]);
    end

    // Bus source mux; out-of-range selects drive zero and flag an error.
    always_comb begin
        bus     = '0;
        sel_bad = 1'b0;
        if (select == SEL_W'(SEL_NONE)) begin
            bus = '0;
        end else if (select == SEL_W'(SEL_MEM)) begin
            bus = rdata;
        end else if (select == SEL_W'(SEL_EXT)) begin
            bus = data_in;
        end else if (select > SEL_W'(SEL_EXT)) begin
            sel_bad = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (select == SEL_W'(SEL_REG_BASE + k)) begin
                    bus = regs[k];
                end
            end
        end
    end

    assign data_out = bus;
    assign mem_addr = regs[ADDR_IDX][MEM_AW-1:0];

    // Memory array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (write) begin
            mem[mem_addr] <= bus;
        end
    end

    // Write wins a read/write collision; read data holds until the next read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (read && !write) begin
            rdata <= mem[mem_addr];
        end
    end

    always_comb begin
        err_set               = '0;
        err_set[ERR_CONFLICT] = |conflict;
        err_set[ERR_RW]       = read & write;
        err_set[ERR_SEL]      = sel_bad;
    end

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err <= '0;
        end else begin
            err <= (err_clr ? '0 : err) | err_set;
        end
    end

endmodule

// File: tb/tb_param_common_bus.sv
// Bench for param_common_bus: directed scenarios plus randomised traffic
// checked against an array-based behavioural model.
module tb_param_common_bus;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 6;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned MEM_AW   = 8;
    localparam int unsigned ADDR_IDX = 0;
    localparam int unsigned DEPTH    = 1 << MEM_AW;
    localparam int unsigned S_MEM    = NUM_REGS + 1;
    localparam int unsigned S_EXT    = NUM_REGS + 2;

    logic                       clock = 1'b0;
    logic                       reset_n;
    logic [NUM_REGS-1:0]        ld, inr, clr;
    logic [SEL_W-1:0]           select;
    logic                       read, write, err_clr;
    logic [DATA_W-1:0]          data_in;
    logic [DATA_W-1:0]          data_out;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic [2:0]                 err;

    int passed = 0;
    int total  = 0;

    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic [DATA_W-1:0] m_mem  [DEPTH];
    logic [DATA_W-1:0] m_rdata;
    logic [2:0]        m_err;

    always #5 clock = ~clock;

    param_common_bus #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
        .MEM_AW(MEM_AW), .ADDR_IDX(ADDR_IDX)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ld(ld), .inr(inr), .clr(clr),
        .select(select), .read(read), .write(write), .data_in(data_in),
        .err_clr(err_clr), .data_out(data_out), .reg_q(reg_q), .err(err)
    );

    function automatic logic [DATA_W-1:0] model_bus(input logic [SEL_W-1:0] s);
        int si;
        si = int'(s);
        if (si >= 1 && si <= NUM_REGS) return m_regs[si-1];
        if (si == S_MEM) return m_rdata;
        if (si == S_EXT) return data_in;
        return '0;
    endfunction

    function automatic logic [NUM_REGS*DATA_W-1:0] model_regq();
        logic [NUM_REGS*DATA_W-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = m_regs[k];
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] dut_reg(input int k);
        return reg_q[k*DATA_W +: DATA_W];
    endfunction

    task automatic idle();
        ld = '0; inr = '0; clr = '0; select = '0;
        read = 1'b0; write = 1'b0; err_clr = 1'b0; data_in = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        m_rdata = '0;
        m_err   = '0;
    endtask

    // Advance one clock edge, updating the model from the pre-edge inputs and state.
    task automatic step();
        logic [DATA_W-1:0] b;
        logic [2:0]        e;
        int                addr, cnt;
        b    = model_bus(select);
        e    = '0;
        addr = int'(m_regs[ADDR_IDX][MEM_AW-1:0]);
        if (int'(select) > S_EXT) e[2] = 1'b1;
        if (read && write) e[1] = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) begin
            cnt = int'(ld[k]) + int'(inr[k]) + int'(clr[k]);
            if (cnt > 1) e[0] = 1'b1;
            if (clr[k])      m_regs[k] = '0;
            else if (ld[k])  m_regs[k] = b;
            else if (inr[k]) m_regs[k] = m_regs[k] + 1'b1;
        end
        if (write)     m_mem[addr] = b;
        else if (read) m_rdata = m_mem[addr];
        m_err = (err_clr ? 3'b000 : m_err) | e;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        total++;
        if (reg_q !== '0) $display("FAIL reset_regs: got %h expected 0", reg_q);
        else passed++;
        total++;
        if (err !== 3'b000) $display("FAIL reset_err: got %b expected 000", err);
        else passed++;
        select = SEL_W'(S_MEM);
        #1;
        total++;
        if (data_out !== '0) $display("FAIL reset_rdata: got %h expected 0", data_out);
        else passed++;
    endtask

    // Fill every memory word with random data using address auto-increment.
    task automatic preload_mem();
        idle(); clr[ADDR_IDX] = 1'b1; step();
        for (int a = 0; a < int'(DEPTH); a++) begin
            idle();
            select = SEL_W'(S_EXT); data_in = DATA_W'($urandom);
            write = 1'b1; inr[ADDR_IDX] = 1'b1;
            step();
        end
        idle();
        total++;
        if (dut_reg(ADDR_IDX) !== DATA_W'(DEPTH))
            $display("FAIL preload_addr: got %h expected %h", dut_reg(ADDR_IDX), DATA_W'(DEPTH));
        else passed++;
    endtask

    task automatic test_ext_load();
        idle(); select = SEL_W'(S_EXT); data_in = 16'h1234; ld[2] = 1'b1; step();
        total++;
        if (dut_reg(2) !== 16'h1234) $display("FAIL ext_load_reg: got %h expected 1234", dut_reg(2));
        else passed++;
        idle(); select = 4'd3; #1;
        total++;
        if (data_out !== 16'h1234) $display("FAIL ext_load_bus: got %h expected 1234", data_out);
        else passed++;
    endtask

    task automatic test_swap();
        idle(); select = SEL_W'(S_EXT); data_in = 16'hABCD; ld[3] = 1'b1; step();
        idle(); select = 4'd4; ld[2] = 1'b1; step();
        total++;
        if (dut_reg(2) !== 16'hABCD) $display("FAIL swap_reg2: got %h expected abcd", dut_reg(2));
        else passed++;
        idle(); select = 4'd3; #1;
        total++;
        if (data_out !== 16'hABCD) $display("FAIL swap_bus: got %h expected abcd", data_out);
        else passed++;
        idle(); select = 4'd4; ld[3] = 1'b1; step();
        total++;
        if (dut_reg(3) !== 16'hABCD) $display("FAIL self_load: got %h expected abcd", dut_reg(3));
        else passed++;
    endtask

    task automatic test_inc_priority();
        idle(); select = SEL_W'(S_EXT); data_in = 16'hFFFF; ld[1] = 1'b1; step();
        idle(); inr[1] = 1'b1; step();
        total++;
        if (dut_reg(1) !== 16'h0000) $display("FAIL inc_wrap: got %h expected 0000", dut_reg(1));
        else passed++;
        idle(); select = SEL_W'(S_EXT); data_in = 16'h7777;
        clr[1] = 1'b1; ld[1] = 1'b1; inr[1] = 1'b1; step();
        total++;
        if (dut_reg(1) !== 16'h0000) $display("FAIL prio_clr: got %h expected 0000", dut_reg(1));
        else passed++;
        total++;
        if (err !== 3'b001) $display("FAIL conflict_err: got %b expected 001", err);
        else passed++;
        idle(); err_clr = 1'b1; step();
        total++;
        if (err !== 3'b000) $display("FAIL err_clr: got %b expected 000", err);
        else passed++;
    endtask

    task automatic test_mem_round_trip();
        idle(); select = SEL_W'(S_EXT); data_in = 16'h0010; ld[ADDR_IDX] = 1'b1; step();
        idle(); select = SEL_W'(S_EXT); data_in = 16'h5A5A; write = 1'b1; step();
        idle(); read = 1'b1; step();
        idle(); select = SEL_W'(S_MEM); #1;
        total++;
        if (data_out !== 16'h5A5A) $display("FAIL mem_read: got %h expected 5a5a", data_out);
        else passed++;
    endtask

    task automatic test_collision_sel();
        idle(); select = SEL_W'(S_EXT); data_in = 16'h1111; read = 1'b1; write = 1'b1; step();
        total++;
        if (err !== 3'b010) $display("FAIL rw_err: got %b expected 010", err);
        else passed++;
        idle(); read = 1'b1; err_clr = 1'b1; step();
        idle(); select = SEL_W'(S_MEM); #1;
        total++;
        if (data_out !== 16'h1111) $display("FAIL rw_write_done: got %h expected 1111", data_out);
        else passed++;
        total++;
        if (err !== 3'b000) $display("FAIL rw_err_clr: got %b expected 000", err);
        else passed++;
        idle(); select = 4'hF; #1;
        total++;
        if (data_out !== '0) $display("FAIL bad_sel_bus: got %h expected 0", data_out);
        else passed++;
        total++;
        if (err !== 3'b000) $display("FAIL bad_sel_early: got %b expected 000", err);
        else passed++;
        step();
        total++;
        if (err !== 3'b100) $display("FAIL bad_sel_err: got %b expected 100", err);
        else passed++;
        idle(); select = 4'hF; err_clr = 1'b1; step();
        total++;
        if (err !== 3'b100) $display("FAIL clr_vs_new: got %b expected 100", err);
        else passed++;
        idle(); err_clr = 1'b1; step();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            idle();
            ld      = NUM_REGS'($urandom) & NUM_REGS'($urandom);
            inr     = NUM_REGS'($urandom) & NUM_REGS'($urandom);
            clr     = NUM_REGS'($urandom) & NUM_REGS'($urandom) & NUM_REGS'($urandom);
            select  = SEL_W'($urandom_range(0, 15));
            read    = ($urandom_range(0, 2) == 0);
            write   = ($urandom_range(0, 3) == 0);
            err_clr = ($urandom_range(0, 5) == 0);
            data_in = DATA_W'($urandom);
            step();
            total++;
            if (reg_q !== model_regq()) begin
                if (bad < 10) $display("FAIL rand_regs[%0d]: got %h expected %h", i, reg_q, model_regq());
                bad++;
            end else passed++;
            total++;
            if (err !== m_err) begin
                if (bad < 10) $display("FAIL rand_err[%0d]: got %b expected %b", i, err, m_err);
                bad++;
            end else passed++;
            total++;
            if (data_out !== model_bus(select)) begin
                if (bad < 10) $display("FAIL rand_bus[%0d]: got %h expected %h", i, data_out, model_bus(select));
                bad++;
            end else passed++;
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle(); select = SEL_W'(S_EXT); data_in = 16'h0010; ld[ADDR_IDX] = 1'b1; step();
        idle(); select = SEL_W'(S_EXT); data_in = 16'h5A5A; write = 1'b1; ld[5] = 1'b1; step();
        idle(); select = 4'hF; step();
        idle(); read = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (reg_q !== '0) $display("FAIL async_regs: got %h expected 0", reg_q);
        else passed++;
        total++;
        if (err !== 3'b000) $display("FAIL async_err: got %b expected 000", err);
        else passed++;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        idle(); select = SEL_W'(S_MEM); step();
        total++;
        if (data_out !== '0) $display("FAIL async_rdata: got %h expected 0", data_out);
        else passed++;
        idle(); select = SEL_W'(S_EXT); data_in = 16'h0010; ld[ADDR_IDX] = 1'b1; step();
        idle(); read = 1'b1; step();
        idle(); select = SEL_W'(S_MEM); #1;
        total++;
        if (data_out !== 16'h5A5A) $display("FAIL async_mem_kept: got %h expected 5a5a", data_out);
        else passed++;
    endtask

    initial begin
        reset_n = 1'b1;
        idle();
        @(negedge clock);
        test_reset();
        preload_mem();
        test_ext_load();
        test_swap();
        test_inc_priority();
        test_mem_round_trip();
        test_collision_sel();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/param_common_bus.md
Name: param_common_bus

Overview:
- Parametrised successor to the basic-computer common bus.
- Holds NUM_REGS general registers of DATA_W bits, each with LD/INR/CLR controls.
- Includes a synchronous memory addressed by a designated address register, plus an external input port, all multiplexed onto one shared bus.
- Adds behaviour the fixed 16-bit bus lacks: generic register count and width, a defined same-cycle priority per register, a one-cycle registered memory read, and sticky error flags for illegal control combinations.

Parameters:
- DATA_W, 16, bus and register width.
- NUM_REGS, 6, number of bus registers; register k is selected by select = k+1.
- SEL_W, 4, select width; elaboration error if 2**SEL_W < NUM_REGS+3.
- MEM_AW, 8, memory address width; depth is 2**MEM_AW words of DATA_W.
- ADDR_IDX, 0, index of the register whose low MEM_AW bits address memory.

Ports:
- clock, input, 1, rising-edge system clock.
- reset_n, input, 1, asynchronous active-low reset.
- ld, input, NUM_REGS, per-register load from bus.
- inr, input, NUM_REGS, per-register increment.
- clr, input, NUM_REGS, per-register clear.
- select, input, SEL_W, bus source select.
- read, input, 1, memory read request.
- write, input, 1, memory write of bus value.
- data_in, input, DATA_W, external bus source.
- err_clr, input, 1, clears the sticky error flags.
- data_out, output, DATA_W, current bus value (combinational).
- reg_q, output, NUM_REGS*DATA_W, all register contents flattened; register k occupies bits [k*DATA_W +: DATA_W].
- err, output, 3, sticky flags: [0] control conflict, [1] read/write collision, [2] invalid select.

Behaviour:
- Reset (reset_n=0, asynchronous): all registers 0, memory read-data register 0, err 0. Memory array contents are not reset. A read in flight when reset asserts is discarded; read data stays 0.
- Bus mux (combinational):
  - select 0: bus = 0.
  - select 1..NUM_REGS: bus = register select-1.
  - select NUM_REGS+1: bus = memory read-data register.
  - select NUM_REGS+2: bus = data_in.
  - Any other value: bus = 0 and err[2] sets on the next edge.
- Register update at each rising edge, priority per register: clr > ld > inr > hold.
  - ld captures the pre-edge bus value. A register can load a value sourced from itself or any other register in the same cycle (swap-safe; no combinational loop through the register).
  - inr wraps from all-ones to 0.
  - Asserting more than one of ld/inr/clr on the same register sets err[0]; the priority result is still applied.
- Memory:
  - write=1: mem[reg ADDR_IDX low MEM_AW bits] <= pre-edge bus.
  - read=1 (and write=0): read-data register <= mem[address] at the edge. Data is visible on the bus (select NUM_REGS+1) from the following cycle. Latency 1 cycle; the read-data register holds until the next read.
  - read and write in the same cycle: write performed, read ignored, err[1] set.
  - Address register updated in the same cycle as a read/write: the access uses the pre-edge address.
- Errors: sticky until err_clr=1. If err_clr and a new error condition coincide, the new error wins (flag stays 1).
- Widths: all arithmetic is modulo 2**DATA_W. The address is truncated to MEM_AW bits.

Decomposition:
- Shared include common_bus_defs: SEL_NONE=0, the SEL_REG_BASE offset, the SEL_MEM and SEL_EXT offset formulas relative to NUM_REGS, and error bit indices ERR_CONFLICT/ERR_RW/ERR_SEL.
- One sub-module, bus_reg: a single DATA_W register with clr/ld/inr priority and async active-low reset, instantiated NUM_REGS times via generate.
- Bus mux, memory and error logic stay in the top level.

Test Plan:
- External load: reset, select=8, data_in=16'h1234, ld[2]=1 for one cycle -> reg 2 = 16'h1234; select=3 -> data_out=16'h1234.
- Same-cycle swap: reg 3=16'hABCD, reg 2=16'h1234; select=4, ld[2]=1 -> reg 2 = 16'hABCD, data_out then shows 16'hABCD. Holding select=4 with ld[3]=1 next cycle -> reg 3 keeps 16'hABCD.
- Increment wrap and priority: reg 1=16'hFFFF, inr[1] -> 0; clr[1]+ld[1]+inr[1] together -> reg 1 = 0 and err=3'b001; err_clr -> err=0.
- Memory round trip: reg 0=16'h0010, select=8, data_in=16'h5A5A, write=1 -> mem[0x10]=16'h5A5A; next cycle read=1; cycle after, select=7 -> data_out=16'h5A5A.
- Collision and invalid select: read=write=1 -> write done, err[1]=1; select=4'hF -> data_out=0, err[2]=1 next edge.
- Async reset mid-operation: assert reset_n=0 between edges during a pending read -> reg_q=0, err=0 immediately; read-data stays 0 after release; memory retains 16'h5A5A.
